// File: rtl/sync_xy_split5_32b.sv
// Generic FIFO: circular buffer with count register, no full-bypass.
// Latency: written entry is visible at rd_dat the cycle after the write edge.
// Backpressure: wr_rdy = !full (forced low in reset), never relaxed by a same-cycle read.
module sync_xy_split5_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;

    assign wr_rdy = rst_n & (count_q < CNT_FULL);
    assign rd_vld = (count_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign wr_en  = wr_vld & wr_rdy;
    assign rd_en  = rd_vld & rd_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
    end
endmodule

// XY dimension-order 1-to-5 flit distributor: FIFO head steered into per-port holding registers.
// Latency: flit accepted at edge E drives its output after edge E+1 (empty FIFO, free register).
// Backpressure: o_free = FIFO not full; a blocked head stalls all later flits, other outputs drain freely.
module sync_xy_split5_32b #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [3:0]  LOCAL_X = 4'd1,
    parameter logic [3:0]  LOCAL_Y = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_drive,
    input  logic [31:0] i_data_32,
    output logic        o_free,
    output logic        o_drive0,
    output logic        o_drive1,
    output logic        o_drive2,
    output logic        o_drive3,
    output logic        o_drive4,
    output logic [31:0] o_data0_32,
    output logic [31:0] o_data1_32,
    output logic [31:0] o_data2_32,
    output logic [31:0] o_data3_32,
    output logic [31:0] o_data4_32,
    input  logic        i_freeNext0,
    input  logic        i_freeNext1,
    input  logic        i_freeNext2,
    input  logic        i_freeNext3,
    input  logic        i_freeNext4
);
    typedef struct packed {
        logic [3:0]  dst_x;
        logic [3:0]  dst_y;
        logic [23:0] payload;
    } flit_t;

    localparam int NPORT = 5;

    flit_t             head_dat;
    logic              head_vld;
    logic              pop;
    logic [NPORT-1:0]  route_oh;
    logic [NPORT-1:0]  free_next;
    logic [NPORT-1:0]  drain;
    logic [NPORT-1:0]  load;
    logic [NPORT-1:0]  drv_q, drv_d;
    flit_t             dat_q [NPORT];
    flit_t             dat_d [NPORT];

    sync_xy_split5_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk    (clk),
        .rst_n  (rst),
        .wr_vld (i_drive),
        .wr_rdy (o_free),
        .wr_dat (i_data_32),
        .rd_vld (head_vld),
        .rd_rdy (pop),
        .rd_dat (head_dat)
    );

    assign free_next = {i_freeNext4, i_freeNext3, i_freeNext2, i_freeNext1, i_freeNext0};

    // X is resolved first; Y only matters once the column matches.
    always_comb begin
        route_oh = '0;
        if (head_dat.dst_x > LOCAL_X)      route_oh[1] = 1'b1;
        else if (head_dat.dst_x < LOCAL_X) route_oh[0] = 1'b1;
        else if (head_dat.dst_y > LOCAL_Y) route_oh[2] = 1'b1;
        else if (head_dat.dst_y < LOCAL_Y) route_oh[3] = 1'b1;
        else                               route_oh[4] = 1'b1;
    end

    assign drain = drv_q & free_next;
    assign pop   = head_vld & |(route_oh & (~drv_q | drain));
    assign load  = pop ? route_oh : '0;

    always_comb begin
        drv_d = (drv_q & ~drain) | load;
        for (int p = 0; p < NPORT; p++) begin
            dat_d[p] = load[p] ? head_dat : dat_q[p];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drv_q <= '0;
            for (int p = 0; p < NPORT; p++) dat_q[p] <= '0;
        end else begin
            drv_q <= drv_d;
            for (int p = 0; p < NPORT; p++) dat_q[p] <= dat_d[p];
        end
    end

    assign o_drive0   = drv_q[0];
    assign o_drive1   = drv_q[1];
    assign o_drive2   = drv_q[2];
    assign o_drive3   = drv_q[3];
    assign o_drive4   = drv_q[4];
    assign o_data0_32 = dat_q[0];
    assign o_data1_32 = dat_q[1];
    assign o_data2_32 = dat_q[2];
    assign o_data3_32 = dat_q[3];
    assign o_data4_32 = dat_q[4];
endmodule

// File: tb/tb_sync_xy_split5_32b.sv
// Bench for sync_xy_split5_32b: directed cycle checks plus random traffic against per-port order queues.
module tb_sync_xy_split5_32b;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_drive;
    logic [31:0] i_data;
    logic [4:0]  fnx;
    wire         o_free;
    wire  [4:0]  drv;
    wire  [31:0] dat [5];

    int          n_cmp = 0;
    int          n_err = 0;
    bit          acc_last = 1'b0;
    bit          sb_on = 1'b0;
    logic [31:0] got   [5][$];
    logic [31:0] exp_q [5][$];
    logic [31:0] f [8];

    always #5 clk = ~clk;

    sync_xy_split5_32b dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .i_data_32   (i_data),
        .o_free      (o_free),
        .o_drive0    (drv[0]),
        .o_drive1    (drv[1]),
        .o_drive2    (drv[2]),
        .o_drive3    (drv[3]),
        .o_drive4    (drv[4]),
        .o_data0_32  (dat[0]),
        .o_data1_32  (dat[1]),
        .o_data2_32  (dat[2]),
        .o_data3_32  (dat[3]),
        .o_data4_32  (dat[4]),
        .i_freeNext0 (fnx[0]),
        .i_freeNext1 (fnx[1]),
        .i_freeNext2 (fnx[2]),
        .i_freeNext3 (fnx[3]),
        .i_freeNext4 (fnx[4])
    );

    // Reference routing for this router at (1,1).
    function automatic int route_ref(input logic [31:0] d);
        int dx = int'(d[31:28]);
        int dy = int'(d[27:24]);
        if (dx > 1) return 1;
        if (dx < 1) return 0;
        if (dy > 1) return 2;
        if (dy < 1) return 3;
        return 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Record what transfers at the coming edge, then move to 1 time unit after it.
    task automatic step();
        acc_last = i_drive && o_free;
        if (acc_last && sb_on) exp_q[route_ref(i_data)].push_back(i_data);
        for (int p = 0; p < 5; p++) if (drv[p] && fnx[p]) got[p].push_back(dat[p]);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        i_data  = d;
        i_drive = 1'b1;
        do begin
            step();
            n++;
        end while (!acc_last && n < 30);
        chk("send_accepted", {31'd0, acc_last}, 32'd1);
        i_drive = 1'b0;
    endtask

    task automatic clear_got();
        for (int p = 0; p < 5; p++) got[p].delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; i_drive = 1'b0; i_data = '0; fnx = '0;
        #1;
        chk("rst_free", {31'd0, o_free}, 32'd0);
        chk("rst_drive", {27'd0, drv}, 32'd0);
        for (int p = 0; p < 5; p++) chk("rst_data", dat[p], 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("free_after_release", {31'd0, o_free}, 32'd1);

        // Single flit to east, latency and drain.
        send(32'h2100_00AA);
        chk("t1_not_yet", {27'd0, drv}, 32'd0);
        step();
        chk("t1_drive", {27'd0, drv}, 32'h02);
        chk("t1_data", dat[1], 32'h2100_00AA);
        fnx[1] = 1'b1;
        step();
        chk("t1_drained", {27'd0, drv}, 32'd0);
        fnx = '0;

        // Route coverage to west, north, south, local.
        clear_got();
        fnx = 5'h1f;
        send(32'h0100_0001);
        send(32'h1200_0002);
        send(32'h1000_0003);
        send(32'h1100_0004);
        repeat (6) step();
        chk("t2_n0", got[0].size(), 32'd1);
        chk("t2_n1", got[1].size(), 32'd0);
        chk("t2_n2", got[2].size(), 32'd1);
        chk("t2_n3", got[3].size(), 32'd1);
        chk("t2_n4", got[4].size(), 32'd1);
        if (got[0].size() > 0) chk("t2_d0", got[0][0], 32'h0100_0001);
        if (got[2].size() > 0) chk("t2_d2", got[2][0], 32'h1200_0002);
        if (got[3].size() > 0) chk("t2_d3", got[3][0], 32'h1000_0003);
        if (got[4].size() > 0) chk("t2_d4", got[4][0], 32'h1100_0004);

        // Backpressure on east until the FIFO fills.
        fnx = '0;
        for (int i = 0; i < 6; i++) f[i] = 32'h2000_0010 + i;
        for (int i = 0; i < 5; i++) send(f[i]);
        i_data = f[5]; i_drive = 1'b1;
        repeat (3) step();
        chk("t3_held", {31'd0, acc_last}, 32'd0);
        chk("t3_full_free", {31'd0, o_free}, 32'd0);
        chk("t3_drive", {27'd0, drv}, 32'h02);
        chk("t3_reg1", dat[1], f[0]);
        fnx[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("t3_stream_drv", {31'd0, drv[1]}, 32'd1);
            chk("t3_stream_dat", dat[1], f[k]);
            step();
            if (acc_last) i_drive = 1'b0;
        end
        chk("t3_empty", {27'd0, drv}, 32'd0);
        chk("t3_free_back", {31'd0, o_free}, 32'd1);
        fnx = '0;

        // Head-of-line blocking: D to local waits behind B and C on west.
        send(32'h0000_00A0);
        send(32'h0000_00B0);
        send(32'h0000_00C0);
        send(32'h1100_00D0);
        repeat (2) step();
        chk("t4_a_drv", {27'd0, drv}, 32'h01);
        chk("t4_a_dat", dat[0], 32'h0000_00A0);
        fnx[0] = 1'b1; step(); fnx[0] = 1'b0;
        chk("t4_b_drv", {27'd0, drv}, 32'h01);
        chk("t4_b_dat", dat[0], 32'h0000_00B0);
        step();
        chk("t4_d_blocked", {27'd0, drv}, 32'h01);
        fnx[0] = 1'b1; step(); fnx[0] = 1'b0;
        chk("t4_c_drv", {27'd0, drv}, 32'h01);
        chk("t4_c_dat", dat[0], 32'h0000_00C0);
        step();
        chk("t4_d_drv", {27'd0, drv}, 32'h11);
        chk("t4_d_dat", dat[4], 32'h1100_00D0);
        fnx = 5'h1f;
        repeat (3) step();
        chk("t4_clean", {27'd0, drv}, 32'd0);

        // Refill of a draining register on the same edge.
        fnx = 5'h10;
        send(32'h1100_0E01);
        send(32'h1100_0E02);
        chk("t5_e1_drv", {27'd0, drv}, 32'h10);
        chk("t5_e1_dat", dat[4], 32'h1100_0E01);
        step();
        chk("t5_e2_drv", {27'd0, drv}, 32'h10);
        chk("t5_e2_dat", dat[4], 32'h1100_0E02);
        step();
        chk("t5_idle", {27'd0, drv}, 32'd0);

        // FIFO at two entries with simultaneous read and write.
        fnx = '0;
        clear_got();
        for (int i = 0; i < 7; i++) f[i] = 32'h0000_0A00 + (i << 4);
        send(f[0]); send(f[1]); send(f[2]);
        i_data = f[3]; i_drive = 1'b1; fnx[0] = 1'b1;
        step();
        chk("t5_rw_acc", {31'd0, acc_last}, 32'd1);
        i_drive = 1'b0; fnx[0] = 1'b0;
        send(f[4]); send(f[5]);
        i_data = f[6]; i_drive = 1'b1;
        step();
        chk("t5_full_hold", {31'd0, acc_last}, 32'd0);
        chk("t5_full_free", {31'd0, o_free}, 32'd0);
        fnx[0] = 1'b1;
        send(f[6]);
        repeat (8) step();
        chk("t5_order_n", got[0].size(), 32'd7);
        for (int i = 0; i < 7; i++)
            if (i < got[0].size()) chk("t5_order", got[0][i], f[i]);
        fnx = '0;

        // Asynchronous reset with flits buffered.
        send(32'h1200_0001); send(32'h1200_0002); send(32'h1200_0003); send(32'h1200_0004);
        step();
        chk("t6_pre_drv", {27'd0, drv}, 32'h04);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_rst_drv", {27'd0, drv}, 32'd0);
        chk("t6_rst_free", {31'd0, o_free}, 32'd0);
        for (int p = 0; p < 5; p++) chk("t6_rst_dat", dat[p], 32'd0);
        @(posedge clk); #1;
        chk("t6_rst_hold", {27'd0, drv}, 32'd0);
        rst = 1'b1;
        fnx = 5'h1f;
        clear_got();
        repeat (6) step();
        chk("t6_no_stale", got[0].size() + got[1].size() + got[2].size() + got[3].size() + got[4].size(), 32'd0);
        chk("t6_free", {31'd0, o_free}, 32'd1);

        // Random traffic checked against per-port order queues.
        sb_on = 1'b1;
        acc_last = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            fnx = 5'($urandom);
            if (!i_drive || acc_last) begin
                i_drive = ($urandom_range(0, 3) != 0);
                i_data  = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 24'($urandom)};
            end
            step();
        end
        i_drive = 1'b0;
        fnx = 5'h1f;
        repeat (20) step();
        sb_on = 1'b0;
        for (int p = 0; p < 5; p++) begin
            chk("rnd_count", got[p].size(), exp_q[p].size());
            for (int i = 0; i < got[p].size() && i < exp_q[p].size(); i++)
                chk("rnd_data", got[p][i], exp_q[p][i]);
        end
        chk("rnd_idle", {27'd0, drv}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
